// File: rtl/pancham_pkg.sv
// Shared types and helpers for the pancham MD5 front end.
// Holds core bus widths, the packer state set and the width encoding.
package pancham_pkg;

    localparam int MD5_MSG_W = 128;
    localparam int MD5_WID_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        WAIT_CORE,
        ISSUE,
        BUSY
    } packer_state_t;

    // Byte count to bit width; 16 bytes maps to 8'h80.
    function automatic logic [MD5_WID_W-1:0] width_of(input logic [4:0] cnt);
        return {cnt, 3'b000};
    endfunction

endpackage

// File: rtl/pancham_byte_shifter.sv
// Byte buffer for the packer: write at the running index, clear, count.
// Byte k sits at value bits [8k+7:8k] so the first byte is least significant.
module pancham_byte_shifter
    import pancham_pkg::*;
#(
    parameter int MAX_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   wr,
    input  logic [7:0]             din,
    output logic [MAX_BYTES*8-1:0] data,
    output logic [4:0]             count,
    output logic                   full
);

    logic [7:0] mem [MAX_BYTES];

    assign full = (count == 5'(MAX_BYTES));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
        end else if (wr && !full) begin
            mem[count[3:0]] <= din;
            count <= count + 5'd1;
        end
    end

    for (genvar k = 0; k < MAX_BYTES; k++) begin : g_pack
        assign data[8*k +: 8] = mem[k];
    end

endmodule

// File: rtl/pancham_msg_packer.sv
// Byte-stream to single-block front end for the pancham MD5 core.
// Packs up to 16 bytes, issues one msg_in_valid, then waits for the digest.
module pancham_msg_packer
    import pancham_pkg::*;
#(
    parameter int MAX_BYTES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         s_last,
    input  logic         s_nul,
    output logic [0:127] md_msg,
    output logic [0:7]   md_width,
    output logic         md_valid,
    input  logic         md_ready,
    input  logic         md_done,
    output logic         err_ovf
);

    packer_state_t state;

    logic [MD5_MSG_W-1:0] buf_data;
    logic [4:0]           count;
    logic                 full;
    logic                 collecting;
    logic                 byte_beat;
    logic                 ovf_beat;
    logic                 sh_wr;
    logic                 sh_clr;

    assign s_ready    = (state == IDLE) || (state == COLLECT) ||
                        (state == DRAIN);
    assign collecting = (state == IDLE) || (state == COLLECT);
    assign byte_beat  = s_valid && collecting && !s_nul;
    assign ovf_beat   = byte_beat && full;
    assign sh_wr      = byte_beat && !full;
    assign sh_clr     = ovf_beat || ((state == BUSY) && md_done);

    pancham_byte_shifter #(
        .MAX_BYTES(MAX_BYTES)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .clr  (sh_clr),
        .wr   (sh_wr),
        .din  (s_data),
        .data (buf_data),
        .count(count),
        .full (full)
    );

    assign md_msg   = buf_data;
    assign md_width = width_of(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            md_valid <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            md_valid <= 1'b0;
            err_ovf  <= 1'b0;
            unique case (state)
                IDLE, COLLECT: begin
                    if (ovf_beat) begin
                        err_ovf <= 1'b1;
                        state   <= s_last ? IDLE : DRAIN;
                    end else if (s_valid && s_last) begin
                        state <= WAIT_CORE;
                    end else if (byte_beat) begin
                        state <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (s_valid && s_last) state <= IDLE;
                end
                WAIT_CORE: begin
                    if (md_ready) begin
                        state    <= ISSUE;
                        md_valid <= 1'b1;
                    end
                end
                // A done arriving alongside md_valid belongs to no message.
                ISSUE: state <= BUSY;
                BUSY: begin
                    if (md_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pancham_msg_packer.sv
// Directed bench for pancham_msg_packer with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns after rising.
module tb_pancham_msg_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_data = '0;
    logic         s_last = 1'b0;
    logic         s_nul = 1'b0;
    logic [0:127] md_msg;
    logic [0:7]   md_width;
    logic         md_valid;
    logic         md_ready = 1'b1;
    logic         md_done = 1'b0;
    logic         err_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cycles = 0;
    int ovf_cycles = 0;
    int v0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (md_valid) valid_cycles++;
        if (err_ovf) ovf_cycles++;
    end

    pancham_msg_packer dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_nul   (s_nul),
        .md_msg  (md_msg),
        .md_width(md_width),
        .md_valid(md_valid),
        .md_ready(md_ready),
        .md_done (md_done),
        .err_ovf (err_ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic n);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_nul   = n;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_nul   = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
    endtask

    // Called right after the last beat edge with md_ready already high.
    task automatic expect_issue(input string tag, input logic [127:0] msg,
                                input logic [7:0] wid);
        check({tag, "_sready_wait"}, 128'(s_ready), 128'(0));
        check({tag, "_valid_early"}, 128'(md_valid), 128'(0));
        tick();
        check({tag, "_valid"}, 128'(md_valid), 128'(1));
        check({tag, "_msg"}, md_msg, msg);
        check({tag, "_width"}, 128'(md_width), 128'(wid));
        tick();
        check({tag, "_valid_once"}, 128'(md_valid), 128'(0));
        check({tag, "_msg_busy"}, md_msg, msg);
        done_pulse();
        check({tag, "_sready_back"}, 128'(s_ready), 128'(1));
    endtask

    initial begin
        repeat (3) tick();
        check("rst_sready", 128'(s_ready), 128'(1));
        check("rst_msg", md_msg, 128'(0));
        check("rst_width", 128'(md_width), 128'(0));
        check("rst_valid", 128'(md_valid), 128'(0));
        check("rst_ovf", 128'(err_ovf), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // Empty message
        beat(8'h00, 1'b1, 1'b1);
        expect_issue("empty", 128'(0), 8'h00);

        // "abc"
        beat(8'h61, 1'b0, 1'b0);
        beat(8'h62, 1'b0, 1'b0);
        beat(8'h63, 1'b1, 1'b0);
        expect_issue("abc", 128'h636261, 8'h18);

        // Full 16-byte message "0123456789abcdef"
        for (int i = 0; i < 10; i++) beat(8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) beat(8'h61 + 8'(i), i == 5, 1'b0);
        check("full_top_byte", 128'(md_msg[0:7]), 128'h66);
        expect_issue("full",
                     128'h66656463_62613938_37363534_33323130, 8'h80);
        check("full_no_ovf", 128'(ovf_cycles), 128'(0));

        // 20-byte message: dropped on byte 17, rest drained
        v0 = valid_cycles;
        for (int i = 0; i < 17; i++) beat(8'h41 + 8'(i), 1'b0, 1'b0);
        check("ovf_pulse", 128'(err_ovf), 128'(1));
        check("ovf_cleared_msg", md_msg, 128'(0));
        beat(8'h52, 1'b0, 1'b0);
        check("ovf_pulse_end", 128'(err_ovf), 128'(0));
        beat(8'h53, 1'b0, 1'b0);
        beat(8'h54, 1'b1, 1'b0);
        tick();
        check("ovf_one_pulse", 128'(ovf_cycles), 128'(1));
        check("ovf_no_issue", 128'(valid_cycles), 128'(v0));
        check("ovf_sready", 128'(s_ready), 128'(1));
        beat(8'h61, 1'b1, 1'b0);
        expect_issue("after_ovf", 128'h61, 8'h08);

        // Core back-pressure with a stray done while waiting
        md_ready = 1'b0;
        beat(8'h78, 1'b0, 1'b0);
        beat(8'h79, 1'b1, 1'b0);
        v0 = valid_cycles;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) md_done = 1'b1;
            tick();
            md_done = 1'b0;
            check("bp_sready", 128'(s_ready), 128'(0));
            check("bp_valid", 128'(md_valid), 128'(0));
        end
        @(negedge clk);
        md_ready = 1'b1;
        tick();
        check("bp_valid_rise", 128'(md_valid), 128'(1));
        check("bp_msg", md_msg, 128'h7978);
        check("bp_width", 128'(md_width), 128'h10);
        tick();
        check("bp_valid_once", 128'(md_valid), 128'(0));
        done_pulse();
        check("bp_sready_back", 128'(s_ready), 128'(1));
        check("bp_one_issue", 128'(valid_cycles - v0), 128'(1));

        // Reset after 5 bytes
        for (int i = 0; i < 5; i++) beat(8'h10 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rst5_msg", md_msg, 128'(0));
        check("rst5_width", 128'(md_width), 128'(0));
        check("rst5_sready", 128'(s_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;

        // Reset while in BUSY
        beat(8'h7a, 1'b1, 1'b0);
        tick();
        tick();
        v0 = valid_cycles;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rstb_valid", 128'(md_valid), 128'(0));
        check("rstb_msg", md_msg, 128'(0));
        check("rstb_sready", 128'(s_ready), 128'(1));
        @(negedge clk);
        reset = 1'b0;

        // Reset while md_valid is up
        beat(8'h55, 1'b1, 1'b0);
        tick();
        check("rsti_valid_up", 128'(md_valid), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rsti_valid_drop", 128'(md_valid), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        check("rst_no_extra", 128'(valid_cycles - v0), 128'(1));

        beat(8'h6b, 1'b1, 1'b0);
        expect_issue("post_rst", 128'h6b, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
